hub75_rx: RTL and testbench
===========================

# hub75_rx

HUB75 panel-side receiver: oversamples the SCLK/LATCH/BLANK/ADDR/RGB lines that `ledscan` drives toward a 64x64 1/32-scan panel, rebuilds each latched row pair in a double-buffered shift register, and drains it as a pixel write stream. It sits behind a PMOD input in a loopback or sniffer build, feeding a framebuffer writer. It is used to verify scan timing and to emulate a panel on a second board.

## Interface
- `WIDTH`, 64: pixels shifted per row per half.
- `ROWS`, 32: scan rows; the bottom half is `y = addr + ROWS`.
- `SYNC_STAGES`, 2: synchronizer depth on all HUB75 inputs.

- `clk` in 1: system clock; at least 4x the SCLK frequency.
- `resetn` in 1: synchronous, active-low reset.
- `hub_sclk` in 1: asynchronous; pixel shift clock.
- `hub_latch` in 1: asynchronous; a rising edge commits the row.
- `hub_blank` in 1: asynchronous; output-enable, active high.
- `hub_addr` in 5: asynchronous; row address.
- `hub_rgb0` in 3: asynchronous; top-half pixel, {B,G,R}.
- `hub_rgb1` in 3: asynchronous; bottom-half pixel, {B,G,R}.
- `px_valid` out 1: pixel beat valid.
- `px_ready` in 1: sink accepts the beat.
- `px_x` out 6: column.
- `px_y` out 6: row, 0..63.
- `px_rgb` out 3: {B,G,R}.
- `row_done` out 1: one-cycle pulse when the last beat of a row is accepted.
- `overrun` out 1: one-cycle pulse when a latch is dropped.
- `len_err` out 1: one-cycle pulse when the SCLK count ≠ WIDTH at latch.
- `blanked` out 1: synchronized `hub_blank`.

## Operation
- All inputs pass through `SYNC_STAGES` flops, including data lines, so data and SCLK arrive equally delayed.
- SCLK rising edge (synchronized sample 1, previous sample 0):
  - Shift {rgb1,rgb0} in at index WIDTH-1; older entries move toward index 0.
  - Increment `col_cnt`, saturating at WIDTH+1.
- After exactly WIDTH clocks, the first pixel received sits at x=0.
- LATCH rising edge, buffer not draining:
  - Copy the shift register to the drain buffer and capture `hub_addr` as `row`.
  - Pulse `len_err` if `col_cnt != WIDTH`; the row is still emitted.
  - Clear `col_cnt`. The shift register is not cleared.
- LATCH rising edge while draining: pulse `overrun`, discard the new row, clear `col_cnt`, continue the drain.
- SCLK and LATCH edges detected in the same cycle: shift first, and the latched row includes that pixel.
- State machine:
  - IDLE → DRAIN on an accepted latch.
  - DRAIN → IDLE when beat 2*WIDTH-1 is accepted; `row_done` pulses in that cycle.
- Capture continues in every state.
- Drain order:
  - Top half: x = 0..WIDTH-1, y = row, rgb0 entries.
  - Bottom half: x = 0..WIDTH-1, y = row+ROWS, rgb1 entries.
- Handshake:
  - `px_x`, `px_y` and `px_rgb` stay stable while `px_valid && !px_ready`.
  - The beat index advances only on `px_valid && px_ready`.
- BLANK does not affect capture. It is only reported on `blanked`.
- `px_y` is computed 6-bit: `{1'b0,row}` for the top half, `{1'b1,row}` for the bottom half.

## Timing
- Reset:
  - `px_valid`, `row_done`, `overrun`, `len_err` and `blanked` are 0. `px_x`, `px_y` and `px_rgb` are 0.
  - `col_cnt` = 0, state = IDLE, shift and drain buffers zeroed.
- Reset asserted mid-drain: `px_valid` is 0 on the next cycle and the drain is abandoned.
- SCLK high and low times must each be ≥ 2 `clk` periods.
- Latency:
  - Latch pin edge → drain buffer loaded after `SYNC_STAGES`+1 `clk`.
  - `px_valid` rises on the following cycle.
- Throughput: one beat per cycle with `px_ready` held high, so a row takes 2*WIDTH = 128 cycles.

## Structure
- Shared package/include `hub75_pkg` holds:
  - WIDTH, ROWS and the RGB bit indices (R=0, G=1, B=2).
  - The state encodings IDLE and DRAIN.
- Sub-module `hub75_sync`: parameterized multi-bit synchronizer with rising-edge outputs for SCLK and LATCH. It is instantiated once.

## Test plan
- Exactly 64 SCLKs, with pixel k carrying rgb0=k%8 and rgb1=~k%8, then latch with addr=5:
  - Expect 128 beats: (x,5,k%8) for the top half, then (x,37,~x%8) for the bottom half.
  - Expect `row_done` once, no `len_err`.
- 70 SCLKs, then latch: `len_err` pulses, and the last 64 pixels appear at x=0..63.
- `px_ready` toggled pseudo-randomly during a drain: no beat lost or duplicated, and outputs stay stable while stalled.
- Second latch 40 cycles into a drain with `px_ready`=1: `overrun` pulses, and the first row completes intact.
- SCLK and LATCH edges in the same cycle after 63 prior clocks: no `len_err`, and the 64th pixel is at x=63.
- `resetn` low for 1 cycle mid-drain: `px_valid` is 0 the next cycle, and the following latched row drains normally from x=0.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared constants, state encodings and bus layouts for the HUB75 panel-side receiver.
package hub75_pkg;

    localparam int unsigned WIDTH       = 64;
    localparam int unsigned ROWS        = 32;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned RGB_W       = 3;

    localparam int unsigned RGB_R = 0;
    localparam int unsigned RGB_G = 1;
    localparam int unsigned RGB_B = 2;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    typedef logic [RGB_W-1:0] rgb_t;

    // Raw HUB75 lines as one vector so they share a single synchronizer
    typedef struct packed {
        rgb_t              rgb1;
        rgb_t              rgb0;
        logic [ADDR_W-1:0] addr;
        logic              blank;
        logic              latch;
        logic              sclk;
    } hub_bus_t;

    localparam int unsigned HUB_W     = $bits(hub_bus_t);
    localparam int unsigned SCLK_BIT  = 0;
    localparam int unsigned LATCH_BIT = 1;

endpackage

// File: rtl/hub75_sync.sv
// Multi-bit input synchronizer with rising-edge detect on the SCLK and LATCH bits.
module hub75_sync
    import hub75_pkg::*;
#(
    parameter int unsigned W         = HUB_W,
    parameter int unsigned STAGES    = SYNC_STAGES,
    parameter int unsigned SCLK_IDX  = SCLK_BIT,
    parameter int unsigned LATCH_IDX = LATCH_BIT
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o,
    output logic         sclk_rise_c,
    output logic         latch_rise_c
);

    logic [W-1:0] stage_q [STAGES];
    logic [1:0]   prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= async_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= {stage_q[STAGES-1][LATCH_IDX], stage_q[STAGES-1][SCLK_IDX]};
        end
    end

    assign sync_o       = stage_q[STAGES-1];
    assign sclk_rise_c  = sync_o[SCLK_IDX]  & ~prev_q[0];
    assign latch_rise_c = sync_o[LATCH_IDX] & ~prev_q[1];

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receiver: captures shifted row pairs, commits them on LATCH and drains them as pixel beats.
module hub75_rx #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned ROWS        = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       hub_sclk,
    input  logic       hub_latch,
    input  logic       hub_blank,
    input  logic [4:0] hub_addr,
    input  logic [2:0] hub_rgb0,
    input  logic [2:0] hub_rgb1,
    output logic       px_valid,
    input  logic       px_ready,
    output logic [5:0] px_x,
    output logic [5:0] px_y,
    output logic [2:0] px_rgb,
    output logic       row_done,
    output logic       overrun,
    output logic       len_err,
    output logic       blanked
);
    import hub75_pkg::*;

    localparam int unsigned XW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(WIDTH + 2);
    localparam int unsigned BW = XW + 1;

    hub_bus_t bus_async;
    hub_bus_t bus_s;
    logic     sclk_rise;
    logic     latch_rise;

    logic [WIDTH-1:0][2:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic [WIDTH-1:0][2:0] dr0_q, dr0_d, dr1_q, dr1_d;
    logic [CW-1:0]         col_q, col_d, col_inc;
    logic [4:0]            row_q, row_d;
    logic [0:0]            state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d, nxt_b;
    logic                  load_out;
    logic                  half;
    logic [XW-1:0]         xi;

    logic       valid_q, valid_d;
    logic [5:0] x_q, x_d, y_q, y_d;
    logic [2:0] rgb_q, rgb_d;
    logic       row_done_q, row_done_d;
    logic       overrun_q, overrun_d;
    logic       len_err_q, len_err_d;
    logic       blanked_q, blanked_d;

    assign bus_async = {hub_rgb1, hub_rgb0, hub_addr, hub_blank, hub_latch, hub_sclk};

    hub75_sync #(
        .W        (HUB_W),
        .STAGES   (SYNC_STAGES),
        .SCLK_IDX (SCLK_BIT),
        .LATCH_IDX(LATCH_BIT)
    ) u_sync (
        .clk         (clk),
        .resetn      (resetn),
        .async_i     (bus_async),
        .sync_o      (bus_s),
        .sclk_rise_c (sclk_rise),
        .latch_rise_c(latch_rise)
    );

    // Capture path runs in every state; drain path presents one beat at a time
    always_comb begin
        sh0_d      = sh0_q;
        sh1_d      = sh1_q;
        dr0_d      = dr0_q;
        dr1_d      = dr1_q;
        col_inc    = col_q;
        col_d      = col_q;
        row_d      = row_q;
        state_d    = state_q;
        beat_d     = beat_q;
        nxt_b      = beat_q;
        load_out   = 1'b0;
        half       = 1'b0;
        xi         = '0;
        valid_d    = valid_q;
        x_d        = x_q;
        y_d        = y_q;
        rgb_d      = rgb_q;
        row_done_d = 1'b0;
        overrun_d  = 1'b0;
        len_err_d  = 1'b0;
        blanked_d  = bus_s.blank;

        if (sclk_rise) begin
            sh0_d   = {bus_s.rgb0, sh0_q[WIDTH-1:1]};
            sh1_d   = {bus_s.rgb1, sh1_q[WIDTH-1:1]};
            col_inc = (col_q == CW'(WIDTH + 1)) ? col_q : col_q + CW'(1);
        end
        col_d = col_inc;

        // A same-cycle SCLK edge is already folded into sh*_d and col_inc
        if (latch_rise) begin
            col_d = '0;
            if (state_q == IDLE) begin
                dr0_d     = sh0_d;
                dr1_d     = sh1_d;
                row_d     = bus_s.addr;
                len_err_d = (col_inc != CW'(WIDTH));
                state_d   = DRAIN;
                beat_d    = '0;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (state_q == DRAIN) begin
            if (!valid_q) begin
                load_out = 1'b1;
            end else if (px_ready) begin
                if (beat_q == BW'(2 * WIDTH - 1)) begin
                    state_d    = IDLE;
                    valid_d    = 1'b0;
                    row_done_d = 1'b1;
                end else begin
                    nxt_b    = beat_q + BW'(1);
                    beat_d   = nxt_b;
                    load_out = 1'b1;
                end
            end
        end

        if (load_out) begin
            half    = nxt_b[XW];
            xi      = nxt_b[XW-1:0];
            valid_d = 1'b1;
            x_d     = 6'(xi);
            y_d     = half ? 6'(row_q) + 6'(ROWS) : 6'(row_q);
            rgb_d   = half ? dr1_q[xi] : dr0_q[xi];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh0_q      <= '0;
            sh1_q      <= '0;
            dr0_q      <= '0;
            dr1_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            state_q    <= IDLE;
            beat_q     <= '0;
            valid_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            rgb_q      <= '0;
            row_done_q <= 1'b0;
            overrun_q  <= 1'b0;
            len_err_q  <= 1'b0;
            blanked_q  <= 1'b0;
        end else begin
            sh0_q      <= sh0_d;
            sh1_q      <= sh1_d;
            dr0_q      <= dr0_d;
            dr1_q      <= dr1_d;
            col_q      <= col_d;
            row_q      <= row_d;
            state_q    <= state_d;
            beat_q     <= beat_d;
            valid_q    <= valid_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rgb_q      <= rgb_d;
            row_done_q <= row_done_d;
            overrun_q  <= overrun_d;
            len_err_q  <= len_err_d;
            blanked_q  <= blanked_d;
        end
    end

    assign px_valid = valid_q;
    assign px_x     = x_q;
    assign px_y     = y_q;
    assign px_rgb   = rgb_q;
    assign row_done = row_done_q;
    assign overrun  = overrun_q;
    assign len_err  = len_err_q;
    assign blanked  = blanked_q;

endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: row capture, length errors, stalls, overrun, edge coincidence, reset.
module tb_hub75_rx;
    import hub75_pkg::*;

    logic       clk = 1'b0;
    logic       resetn;
    logic       hub_sclk, hub_latch, hub_blank;
    logic [4:0] hub_addr;
    logic [2:0] hub_rgb0, hub_rgb1;
    logic       px_valid, px_ready;
    logic [5:0] px_x, px_y;
    logic [2:0] px_rgb;
    logic       row_done, overrun, len_err, blanked;

    int n_assert = 0;
    int n_fail   = 0;
    int c_rd = 0, c_ov = 0, c_le = 0;
    int rd0, ov0, le0;

    logic [2:0] q0 [$];
    logic [2:0] q1 [$];
    logic [5:0] bx [128];
    logic [5:0] by [128];
    logic [2:0] brgb [128];
    int         nb;

    always #5 clk = ~clk;

    hub75_rx dut (
        .clk      (clk),
        .resetn   (resetn),
        .hub_sclk (hub_sclk),
        .hub_latch(hub_latch),
        .hub_blank(hub_blank),
        .hub_addr (hub_addr),
        .hub_rgb0 (hub_rgb0),
        .hub_rgb1 (hub_rgb1),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_x     (px_x),
        .px_y     (px_y),
        .px_rgb   (px_rgb),
        .row_done (row_done),
        .overrun  (overrun),
        .len_err  (len_err),
        .blanked  (blanked)
    );

    always @(negedge clk) begin
        if (row_done) c_rd++;
        if (overrun)  c_ov++;
        if (len_err)  c_le++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] mk_rgb(input logic r, input logic g, input logic b);
        logic [2:0] v;
        v[RGB_R] = r;
        v[RGB_G] = g;
        v[RGB_B] = b;
        return v;
    endfunction

    task automatic send_px(input logic [2:0] c0, input logic [2:0] c1);
        hub_rgb0 = c0;
        hub_rgb1 = c1;
        hub_sclk = 1'b0;
        repeat (3) @(negedge clk);
        hub_sclk = 1'b1;
        repeat (3) @(negedge clk);
        hub_sclk = 1'b0;
        q0.push_back(c0);
        q1.push_back(c1);
    endtask

    task automatic snap();
        rd0 = c_rd;
        ov0 = c_ov;
        le0 = c_le;
    endtask

    // Latch must already be raised; collects 128 accepted beats
    task automatic run_drain(input bit rnd, input int budget, input int relatch_at);
        int         n;
        logic       stall;
        logic [14:0] pb;
        nb = 0; n = 0; stall = 1'b0; pb = '0;
        while (nb < 128 && n < budget) begin
            @(negedge clk);
            if (n == 3) begin
                hub_latch = 1'b0;
                hub_sclk  = 1'b0;
            end
            if (n == relatch_at)     hub_latch = 1'b1;
            if (n == relatch_at + 3) hub_latch = 1'b0;
            if (stall) check("stall_hold", 32'({px_valid, px_x, px_y, px_rgb}), 32'({1'b1, pb}));
            if (rnd) px_ready = 1'($urandom_range(0, 1));
            if (px_valid && px_ready) begin
                bx[nb]   = px_x;
                by[nb]   = px_y;
                brgb[nb] = px_rgb;
                nb++;
            end
            stall = px_valid && !px_ready;
            pb    = {px_x, px_y, px_rgb};
            n++;
        end
        px_ready  = 1'b1;
        hub_latch = 1'b0;
        check("beat_count", 32'(nb), 32'd128);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_row(input string tag, input logic [4:0] row);
        int         base;
        logic [5:0] ey;
        logic [2:0] er;
        base = q0.size() - 64;
        for (int i = 0; i < 128; i++) begin
            ey = (i < 64) ? 6'(row) : 6'(row) + 6'd32;
            er = (i < 64) ? q0[base + (i % 64)] : q1[base + (i % 64)];
            check($sformatf("%s beat %0d", tag, i), 32'({bx[i], by[i], brgb[i]}),
                  32'({6'(i % 64), ey, er}));
        end
    endtask

    task automatic latch_row(input logic [4:0] a);
        hub_addr  = a;
        hub_latch = 1'b1;
    endtask

    initial begin
        int w;
        resetn = 1'b0; hub_sclk = 1'b0; hub_latch = 1'b0; hub_blank = 1'b0;
        hub_addr = '0; hub_rgb0 = '0; hub_rgb1 = '0; px_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(px_valid), 32'd0);
        check("rst_xyrgb", 32'({px_x, px_y, px_rgb}), 32'd0);
        check("rst_pulses", 32'({row_done, overrun, len_err, blanked}), 32'd0);
        resetn = 1'b1;

        // BLANK is only mirrored
        hub_blank = 1'b1;
        repeat (4) @(negedge clk);
        check("blanked_hi", 32'(blanked), 32'd1);
        hub_blank = 1'b0;
        repeat (4) @(negedge clk);
        check("blanked_lo", 32'(blanked), 32'd0);

        // Exact-length row at addr 5
        snap();
        for (int k = 0; k < 64; k++) send_px(3'(k), 3'(~k));
        latch_row(5'd5);
        run_drain(1'b0, 400, -1);
        check_row("t1", 5'd5);
        check("t1_row_done", 32'(c_rd - rd0), 32'd1);
        check("t1_len_err", 32'(c_le - le0), 32'd0);
        check("t1_overrun", 32'(c_ov - ov0), 32'd0);

        // 70 clocks: length error, last 64 pixels kept
        snap();
        for (int k = 0; k < 70; k++) send_px(3'(k), 3'(~k));
        latch_row(5'd10);
        run_drain(1'b0, 400, -1);
        check_row("t2", 5'd10);
        check("t2_len_err", 32'(c_le - le0), 32'd1);
        check("t2_row_done", 32'(c_rd - rd0), 32'd1);

        // Random backpressure, top row address
        snap();
        for (int k = 0; k < 64; k++) send_px(mk_rgb(k[0], k[2], k[1]), 3'(k * 3 + 1));
        latch_row(5'd31);
        run_drain(1'b1, 2000, -1);
        check_row("t3", 5'd31);
        check("t3_row_done", 32'(c_rd - rd0), 32'd1);

        // Second latch mid-drain is dropped
        snap();
        for (int k = 0; k < 64; k++) send_px(3'(k + 3), 3'(k * 5));
        latch_row(5'd0);
        run_drain(1'b0, 400, 44);
        check_row("t4", 5'd0);
        check("t4_overrun", 32'(c_ov - ov0), 32'd1);
        check("t4_row_done", 32'(c_rd - rd0), 32'd1);

        // 64th SCLK edge coincides with LATCH
        snap();
        for (int k = 0; k < 63; k++) send_px(3'(k * 7), mk_rgb(k[1], k[0], k[2]));
        hub_rgb0 = 3'(63 * 7);
        hub_rgb1 = mk_rgb(1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        q0.push_back(hub_rgb0);
        q1.push_back(hub_rgb1);
        hub_addr  = 5'd20;
        hub_sclk  = 1'b1;
        hub_latch = 1'b1;
        run_drain(1'b0, 400, -1);
        check_row("t5", 5'd20);
        check("t5_len_err", 32'(c_le - le0), 32'd0);
        check("t5_x63_rgb", 32'(brgb[63]), 32'(3'(63 * 7)));

        // Reset pulse mid-drain, then a clean row
        for (int k = 0; k < 64; k++) send_px(3'(k), 3'(k));
        latch_row(5'd3);
        w = 0;
        while (!px_valid && w < 20) begin
            @(negedge clk);
            w++;
            if (w == 3) hub_latch = 1'b0;
        end
        hub_latch = 1'b0;
        check("t6_valid_up", 32'(px_valid), 32'd1);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("t6_valid_rst", 32'(px_valid), 32'd0);
        check("t6_x_rst", 32'(px_x), 32'd0);
        snap();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 64; k++) send_px(3'(k + 1), 3'(k + 2));
        latch_row(5'd7);
        run_drain(1'b0, 400, -1);
        check_row("t6", 5'd7);
        check("t6_row_done", 32'(c_rd - rd0), 32'd1);
        check("t6_len_err", 32'(c_le - le0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
